// File: rtl/ghr_checkpoint_ctrl.sv
// Speculative global-history controller: shifts the GHR per accepted prediction,
// checkpoints pre-shift history per tag, restores on mispredict, retires in order.
module ghr_checkpoint_ctrl #(
  parameter int unsigned HIST_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TAG_W  = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              predict_valid,
  input  logic              predict_taken,
  output logic              predict_ready,
  output logic [TAG_W-1:0]  predict_tag,
  output logic [HIST_W-1:0] predict_history,
  input  logic              resolve_valid,
  input  logic [TAG_W-1:0]  resolve_tag,
  input  logic              resolve_taken,
  input  logic              resolve_mispredicted,
  output logic [HIST_W-1:0] commit_history,
  output logic [TAG_W:0]    inflight_count,
  output logic              err
);

  logic [HIST_W-1:0] ckpt [DEPTH];
  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  rel_tag;
  logic              tag_ok;
  logic              mispredict;
  logic              correct;
  logic              illegal;
  logic              full;
  logic              accept;

  // Resolve classification; rel_tag is the branch's age offset from the oldest entry.
  always_comb begin
    rel_tag       = resolve_tag - head;
    tag_ok        = {1'b0, rel_tag} < inflight_count;
    mispredict    = resolve_valid && resolve_mispredicted && tag_ok;
    correct       = resolve_valid && !resolve_mispredicted &&
                    (inflight_count != '0) && (resolve_tag == head);
    illegal       = resolve_valid && !mispredict && !correct;
    full          = inflight_count == (TAG_W+1)'(DEPTH);
    predict_ready = !full && !mispredict;
    accept        = predict_valid && predict_ready;
  end

  // Checkpoint storage holds no control state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) ckpt[predict_tag] <= predict_history;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      predict_history <= '0;
      commit_history  <= '0;
      predict_tag     <= '0;
      head            <= '0;
      inflight_count  <= '0;
      err             <= 1'b0;
    end else begin
      if (mispredict) begin
        // Entry T stays in flight; everything younger is discarded.
        predict_history <= {ckpt[resolve_tag][HIST_W-2:0], resolve_taken};
        predict_tag     <= resolve_tag + TAG_W'(1);
        inflight_count  <= {1'b0, rel_tag} + (TAG_W+1)'(1);
      end else begin
        if (accept) begin
          predict_history <= {predict_history[HIST_W-2:0], predict_taken};
          predict_tag     <= predict_tag + TAG_W'(1);
        end
        if (correct) begin
          commit_history <= {commit_history[HIST_W-2:0], resolve_taken};
          head           <= head + TAG_W'(1);
        end
        inflight_count <= inflight_count + (TAG_W+1)'(accept) - (TAG_W+1)'(correct);
      end
      if (illegal) err <= 1'b1;
    end
  end

endmodule

// File: doc/ghr_checkpoint_ctrl.md
Name: ghr_checkpoint_ctrl

Overview:
- Controller for the speculative global branch-history register (GHR) in the branch predictor front end.
- Shifts the speculative GHR on each accepted prediction and checkpoints the pre-shift history in a circular in-flight queue, tagged per branch.
- On a mispredict, restores the GHR from the mispredicted branch's checkpoint and flushes all younger branches.
- Retires correctly predicted branches in order into an architectural (committed) history.

Parameters:
- HIST_W, 32, GHR width in bits (≥2).
- DEPTH, 8, max in-flight branches (power of 2, ≥2).
- TAG_W, 3, log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  synchronous active-low reset.
- predict_valid  in  1  prediction request from the fetch stage.
- predict_taken  in  1  predicted direction.
- predict_ready  out  1  request accepted this cycle if predict_valid is high.
- predict_tag  out  TAG_W  tag assigned to the current request (= tail pointer).
- predict_history  out  HIST_W  current speculative GHR (pre-shift value used to index the predictor).
- resolve_valid  in  1  branch resolution from execute.
- resolve_tag  in  TAG_W  tag of the resolving branch.
- resolve_taken  in  1  actual direction.
- resolve_mispredicted  in  1  prediction was wrong.
- commit_history  out  HIST_W  architectural history of retired branches.
- inflight_count  out  TAG_W+1  number of occupied entries.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (resetn=0 at posedge):
  - spec GHR=0, commit_history=0, head=tail=0, count=0, err=0.
  - Checkpoint contents are don't-care.
  - Reset mid-operation discards all in-flight entries.
- Status outputs:
  - predict_history, predict_tag, inflight_count are direct register outputs.
  - predict_ready = (count != DEPTH) && !(resolve_valid && resolve_mispredicted && tag_ok). Combinational on the resolve inputs.
- Tag check: tag_ok = ((resolve_tag - head) mod DEPTH) < count.
- Accept (predict_valid && predict_ready):
  - ckpt[tail] <= spec GHR.
  - spec GHR <= {spec GHR[HIST_W-2:0], predict_taken}.
  - tail <= tail+1 mod DEPTH; count +1.
- Correct resolve (resolve_valid && !resolve_mispredicted):
  - Legal only when count>0 and resolve_tag==head.
  - commit_history <= {commit_history[HIST_W-2:0], resolve_taken}.
  - head <= head+1; count −1.
- Mispredict (resolve_valid && resolve_mispredicted && tag_ok), for tag T:
  - spec GHR <= {ckpt[T][HIST_W-2:0], resolve_taken}.
  - tail <= T+1; count <= ((T−head) mod DEPTH)+1.
  - Entry T stays in flight and is retired later by a correct resolve of T.
  - commit_history is unchanged.
  - Any predict in the same cycle is dropped (ready low).
- Same-cycle correct resolve + accepted predict:
  - Both take effect; count is unchanged.
  - When full, ready stays low even if a pop occurs (no bypass).
- Illegal resolve: resolve_valid with (count==0), or !tag_ok, or (correct resolve with tag≠head).
  - Ignored: no state change except err<=1.
  - err is cleared only by reset.
  - An accepted predict in the same cycle still proceeds.
- Pointers wrap modulo DEPTH. GHR shifts discard the MSB. No arithmetic overflow of count (0..DEPTH).
- Latency: all outputs reflect an event on the cycle after its posedge.

Test Plan (HIST_W=32, DEPTH=8):
1. Reset, then predict taken 1,0,1 on consecutive cycles → predict_tag 0,1,2; predict_history 0x0,0x1,0x2 at each request; afterwards predict_history=0x5, inflight_count=3.
2. Reset, 8 predicts taken=1 → predict_ready=0, inflight_count=8, predict_history=0xFF; 9th request ignored; correct resolve of tag 0 (taken=1) → count 7, commit_history=0x1, ready=1 next cycle.
3. Predicts 1,0,1,1 (tags 0–3); mispredict tag 1, taken=1 → predict_history=0x3, count=2, predict_tag=2; next predict taken=0 gets tag 2 and predict_history becomes 0x6.
4. Predicts 1,1,0; correct resolves tags 0,1,2 in order → commit_history=0x6, count=0; simultaneous predict+correct resolve keeps count constant.
5. Mispredict asserted in same cycle as predict_valid → predict_ready=0, prediction not queued, tail=T+1; resolve tag 5 with count=2, or correct resolve with tag≠head → err=1, history/pointers unchanged.
6. Resetn low mid-stream with count=5 → next cycle count=0, predict_history=0, commit_history=0, err=0, predict_tag=0.
